// File: rtl/key_encoder4_pkg.sv
// Shared types for the key encoder: FSM state encoding and key-bus widths.
package key_encoder4_pkg;

    localparam int KEYS   = 4;
    localparam int CODE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEB  = 2'd1,
        S_OUT  = 2'd2,
        S_REL  = 2'd3
    } state_t;

endpackage

// File: rtl/key_encoder4_prio_enc4.sv
// Combinational 4->2 priority encoder: highest-numbered set line wins.
module prio_enc4
    import key_encoder4_pkg::*;
(
    input  logic [KEYS-1:0]   lines,
    output logic [CODE_W-1:0] code,
    output logic              multi,
    output logic              any
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        code = '0;
        casez (lines)
            4'b1???: code = 2'd3;
            4'b01??: code = 2'd2;
            4'b001?: code = 2'd1;
            default: code = 2'd0;
        endcase
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = (lines & (lines - 4'd1)) != '0;
    assign any   = lines != '0;

endmodule

// File: rtl/key_encoder4.sv
// Synchronises, debounces and priority-encodes four key lines into one
// 2-bit code per press, delivered on a valid/ready handshake.
module key_encoder4
    import key_encoder4_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int CW       = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEYS-1:0]   key,
    input  logic              ready,
    output logic              valid,
    output logic [CODE_W-1:0] code,
    output logic              multi,
    output logic              busy
);

    localparam logic [CW-1:0] DEB_LIMIT = CW'(DEBOUNCE);

    logic [KEYS-1:0]   s1, s2, hp;
    logic [CW-1:0]     cnt;
    state_t            state;

    logic [KEYS-1:0]   pat;
    logic [KEYS-1:0]   enc_in;
    logic [CODE_W-1:0] enc_code;
    logic              enc_multi;
    logic              enc_any;
    logic [CW-1:0]     cnt_inc;

    assign pat     = s2;
    assign cnt_inc = cnt + 1'b1;
    assign busy    = (state != S_IDLE);

    // In IDLE the encoder looks at the live pattern so a DEBOUNCE==1 build
    // can report on the very sample that starts the press.
    assign enc_in = (state == S_IDLE) ? pat : hp;

    prio_enc4 u_prio_enc4 (
        .lines (enc_in),
        .code  (enc_code),
        .multi (enc_multi),
        .any   (enc_any)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, which is what makes s1->s2 a real two-stage chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            hp    <= '0;
            cnt   <= '0;
            state <= S_IDLE;
            valid <= 1'b0;
            code  <= '0;
            multi <= 1'b0;
        end else begin
            s1 <= key;
            s2 <= s1;
            case (state)
                S_IDLE: begin
                    if (enc_any) begin
                        hp  <= pat;
                        cnt <= CW'(1);
                        if (DEBOUNCE == 1) begin
                            state <= S_OUT;
                            valid <= 1'b1;
                            code  <= enc_code;
                            multi <= enc_multi;
                        end else begin
                            state <= S_DEB;
                        end
                    end
                end
                S_DEB: begin
                    if (pat == '0) begin
                        state <= S_IDLE;
                    end else if (pat != hp) begin
                        hp  <= pat;
                        cnt <= CW'(1);
                    end else if (cnt_inc == DEB_LIMIT) begin
                        state <= S_OUT;
                        valid <= 1'b1;
                        code  <= enc_code;
                        multi <= enc_multi;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_OUT: begin
                    if (valid && ready) begin
                        state <= S_REL;
                        valid <= 1'b0;
                        cnt   <= '0;
                    end
                end
                S_REL: begin
                    // Any key activity restarts the release count; only a
                    // clean run of zero samples rearms the encoder.
                    if (pat != '0) begin
                        cnt <= '0;
                    end else if (cnt_inc == DEB_LIMIT) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_encoder4.sv
// Directed bench for key_encoder4 with a scoreboard of expected handshakes.
module tb_key_encoder4;

    typedef struct packed {
        logic [1:0] code;
        logic       multi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key, key1;
    logic       ready, ready1;
    logic       valid, multi, busy;
    logic [1:0] code;
    logic       valid1, multi1, busy1;
    logic [1:0] code1;

    int   tests    = 0;
    int   fails    = 0;
    int   ev_count = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    key_encoder4 #(.DEBOUNCE(4), .CW(17)) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .ready (ready),
        .valid (valid),
        .code  (code),
        .multi (multi),
        .busy  (busy)
    );

    key_encoder4 #(.DEBOUNCE(1), .CW(4)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .key   (key1),
        .ready (ready1),
        .valid (valid1),
        .code  (code1),
        .multi (multi1),
        .busy  (busy1)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            step(1);
            n++;
        end
        check(tag, 32'(valid), 32'd1);
    endtask

    // Scoreboard: each accepted handshake must match the oldest expected press.
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            exp_t e;
            ev_count++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_unexpected observed=code%0d/multi%0d expected=no event", code, multi);
            end else begin
                e = sb.pop_front();
                check("sb_code", 32'(code), 32'(e.code));
                check("sb_multi", 32'(multi), 32'(e.multi));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int ev_before;
        rst = 1'b1; key = '0; key1 = '0; ready = 1'b0; ready1 = 1'b0;
        step(2);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_code",  32'(code),  32'd0);
        check("rst_multi", 32'(multi), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        step(2);

        // 1) single key, ready already high: one valid cycle after E0+5
        ready = 1'b1; key = 4'b0100;
        sb.push_back('{code: 2'd2, multi: 1'b0});
        step(5);
        check("t1_early", 32'(valid), 32'd0);
        step(1);
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_code",  32'(code),  32'd2);
        check("t1_multi", 32'(multi), 32'd0);
        check("t1_busy",  32'(busy),  32'd1);
        step(1);
        check("t1_one_cycle", 32'(valid), 32'd0);
        check("t1_rel_busy",  32'(busy),  32'd1);
        key = '0;
        step(8);
        check("t1_idle", 32'(busy), 32'd0);

        // 2) multi-key pattern with a stalled consumer
        ready = 1'b0; key = 4'b1010;
        sb.push_back('{code: 2'd3, multi: 1'b1});
        wait_valid("t2_valid", 20);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t2_hold_valid", 32'(valid), 32'd1);
            check("t2_hold_code",  32'(code),  32'd3);
            check("t2_hold_multi", 32'(multi), 32'd1);
        end
        ready = 1'b1;
        step(1);
        check("t2_accepted", 32'(valid), 32'd0);
        key = '0;
        step(8);
        check("t2_idle", 32'(busy), 32'd0);

        // 3) bounce: the short first pulse must not produce an early event
        key = 4'b0001;
        step(2);
        key = '0;
        step(1);
        key = 4'b0001;
        sb.push_back('{code: 2'd0, multi: 1'b0});
        step(5);
        check("t3_no_early", 32'(valid), 32'd0);
        wait_valid("t3_valid", 10);
        check("t3_code", 32'(code), 32'd0);
        key = '0;
        step(8);
        check("t3_idle", 32'(busy), 32'd0);

        // 4) held key does not repeat; short release does not rearm
        key = 4'b0010;
        sb.push_back('{code: 2'd1, multi: 1'b0});
        wait_valid("t4_valid", 20);
        check("t4_code", 32'(code), 32'd1);
        step(20);
        ev_before = ev_count;
        key = '0;
        step(2);
        key = 4'b0010;
        step(10);
        check("t4_no_repeat", 32'(ev_count), 32'(ev_before));
        check("t4_still_busy", 32'(busy), 32'd1);
        key = '0;
        step(8);
        check("t4_rearmed", 32'(busy), 32'd0);
        key = 4'b0010;
        sb.push_back('{code: 2'd1, multi: 1'b0});
        wait_valid("t4_second", 20);
        key = '0;
        step(8);

        // 5) reset during OUTPUT, key still held afterwards
        ready = 1'b0; key = 4'b1000;
        wait_valid("t5_valid", 20);
        check("t5_code", 32'(code), 32'd3);
        rst = 1'b1;
        step(1);
        check("t5_rst_valid", 32'(valid), 32'd0);
        check("t5_rst_busy",  32'(busy),  32'd0);
        rst = 1'b0;
        sb.push_back('{code: 2'd3, multi: 1'b0});
        step(5);
        check("t5_no_early", 32'(valid), 32'd0);
        step(1);
        check("t5_valid2", 32'(valid), 32'd1);
        check("t5_code2",  32'(code),  32'd3);
        ready = 1'b1;
        step(1);
        check("t5_accepted", 32'(valid), 32'd0);
        key = '0;
        step(8);

        // 6) DEBOUNCE=1 build: valid after E0+2, one zero sample rearms
        ready1 = 1'b1; key1 = 4'b0001;
        step(2);
        check("t6_early", 32'(valid1), 32'd0);
        step(1);
        check("t6_valid", 32'(valid1), 32'd1);
        check("t6_code",  32'(code1),  32'd0);
        step(1);
        check("t6_one_cycle", 32'(valid1), 32'd0);
        key1 = '0;
        step(1);
        key1 = 4'b0001;
        step(2);
        check("t6_rearm_early", 32'(valid1), 32'd0);
        step(1);
        check("t6_rearm_valid", 32'(valid1), 32'd1);
        key1 = '0;
        step(4);

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("event_count", 32'(ev_count), 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
